// File: rtl/psoc_audio_dma_pkg.sv
// psoc_audio_dma_pkg: shared state encoding and sizing constants for the audio sample fetcher
package psoc_audio_dma_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_WAIT, S_REQ_L, S_REQ_R, S_PUSH, S_DONE, S_ERROR
  } state_t;
  localparam int SAMPLE_W = 24;
  localparam int FIFO_W = 48;
  localparam logic [3:0] WB_SEL_ALL = 4'hF;
  localparam logic [31:0] WORD_STRIDE = 32'd4;
endpackage

// File: rtl/psoc_audio_dma_if.sv
// psoc_audio_dma_if: Wishbone read-master bus between the audio fetcher and memory
// Ports: adr/cyc/stb/we/sel driven by master; dat/ack/err driven by slave.
interface psoc_audio_dma_if;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_i;
  logic wbm_cyc_o;
  logic wbm_stb_o;
  logic wbm_we_o;
  logic [3:0] wbm_sel_o;
  logic wbm_ack_i;
  logic wbm_err_i;
  modport master(output wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
                 input wbm_dat_i, wbm_ack_i, wbm_err_i);
  modport slave(input wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
                output wbm_dat_i, wbm_ack_i, wbm_err_i);
endinterface

// File: rtl/psoc_audio_dma.sv
// psoc_audio_dma: Wishbone sample fetcher packing two words per stereo sample into the audio FIFO
// Ports: clk; rst (sync, active-low); enable/loop/base_addr/length config; fifo_full;
//   wbm Wishbone master; audio_data/audio_valid FIFO write; busy/done/error/sample_count status.
import psoc_audio_dma_pkg::*;
module psoc_audio_dma #(
  parameter int LEN_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                loop,
  input  logic [31:0]         base_addr,
  input  logic [LEN_BITS-1:0] length,
  input  logic                fifo_full,
  psoc_audio_dma_if.master    wbm,
  output logic [FIFO_W-1:0]   audio_data,
  output logic                audio_valid,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [LEN_BITS-1:0] sample_count
);
  state_t state_q, state_d;
  logic [31:0] ptr_q, ptr_d, base_q, base_d, adr_q, adr_d;
  logic [LEN_BITS-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] left_q, left_d;
  logic [FIFO_W-1:0] data_q, data_d;
  logic cyc_q, cyc_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = cyc_q;
  assign wbm.wbm_we_o = 1'b0;
  assign wbm.wbm_sel_o = WB_SEL_ALL;
  assign audio_data = data_q;
  assign audio_valid = valid_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = err_q;
  assign sample_count = cnt_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      base_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      left_q <= '0;
      adr_q <= '0;
      data_q <= '0;
      cyc_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      base_q <= base_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      left_q <= left_d;
      adr_q <= adr_d;
      data_q <= data_d;
      cyc_q <= cyc_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  // err takes priority over ack; an abort still waits for the in-flight access to finish
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    base_d = base_q;
    len_d = len_q;
    cnt_d = cnt_q;
    left_d = left_q;
    case (state_q)
      S_IDLE: if (enable) begin
        base_d = base_addr & ~32'h3;
        ptr_d = base_addr & ~32'h3;
        len_d = length;
        cnt_d = '0;
        state_d = (length == '0) ? S_DONE : S_FETCH_WAIT;
      end
      S_FETCH_WAIT: state_d = !enable ? S_IDLE : (fifo_full ? S_FETCH_WAIT : S_REQ_L);
      S_REQ_L: if (wbm.wbm_err_i) state_d = S_ERROR;
        else if (wbm.wbm_ack_i) begin
          left_d = SAMPLE_W'(wbm.wbm_dat_i);
          ptr_d = ptr_q + WORD_STRIDE;
          state_d = enable ? S_REQ_R : S_IDLE;
        end
      S_REQ_R: if (wbm.wbm_err_i) state_d = S_ERROR;
        else if (wbm.wbm_ack_i) begin
          ptr_d = ptr_q + WORD_STRIDE;
          cnt_d = enable ? cnt_q + 1'b1 : cnt_q;
          state_d = enable ? S_PUSH : S_IDLE;
        end
      S_PUSH: if (cnt_q == len_q && loop && enable) begin
          ptr_d = base_q;
          cnt_d = '0;
          state_d = S_FETCH_WAIT;
        end else state_d = !enable ? S_IDLE : (cnt_q == len_q ? S_DONE : S_FETCH_WAIT);
      S_DONE, S_ERROR: state_d = enable ? state_q : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // outputs are computed from the next state so they are registered yet line up with it
  always_comb begin
    busy_d = state_d inside {S_FETCH_WAIT, S_REQ_L, S_REQ_R, S_PUSH};
    cyc_d = state_d inside {S_REQ_L, S_REQ_R};
    adr_d = cyc_d ? ptr_d : adr_q;
    valid_d = state_d == S_PUSH;
    done_d = (state_q == S_IDLE && state_d == S_DONE) || (valid_d && cnt_d == len_q);
    data_d = valid_d ? {left_q, SAMPLE_W'(wbm.wbm_dat_i)} : data_q;
    err_d = (state_q == S_IDLE && enable) ? 1'b0 : (err_q || state_d == S_ERROR);
  end
endmodule

// File: tb/tb_psoc_audio_dma.sv
// tb_psoc_audio_dma: scoreboard bench for the audio sample fetcher against a Wishbone memory model
module tb_psoc_audio_dma;
  typedef struct packed {
    logic [47:0] data;
    logic [15:0] cnt;
    logic done;
  } push_t;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, loop = 1'b0, fifo_full = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] length = '0;
  logic [47:0] audio_data;
  logic audio_valid, busy, done, error;
  logic [15:0] sample_count;
  psoc_audio_dma_if bus();
  psoc_audio_dma #(.LEN_BITS(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .loop(loop), .base_addr(base_addr),
    .length(length), .fifo_full(fifo_full), .wbm(bus), .audio_data(audio_data),
    .audio_valid(audio_valid), .busy(busy), .done(done), .error(error),
    .sample_count(sample_count)
  );
  always #5 clk = ~clk;
  function automatic logic [23:0] lo24(logic [31:0] a);
    return 24'h5A0000 ^ a[23:0];
  endfunction
  int lat = 0, wcnt = 0;
  logic err_en = 1'b0, both = 1'b0, hit, is_err;
  logic [31:0] err_adr = '0;
  assign hit = bus.wbm_cyc_o && bus.wbm_stb_o && (wcnt >= lat);
  assign is_err = err_en && bus.wbm_adr_o == err_adr;
  assign bus.wbm_ack_i = hit && (!is_err || both);
  assign bus.wbm_err_i = hit && is_err;
  assign bus.wbm_dat_i = {8'hEE, lo24(bus.wbm_adr_o)};
  always @(posedge clk) wcnt <= (bus.wbm_cyc_o && bus.wbm_stb_o && !hit) ? wcnt + 1 : 0;
  push_t exp_push[$];
  logic [31:0] exp_adr[$];
  int checks = 0, errors = 0, pushes = 0, dones = 0, cyc_cycles = 0, cycle = 0, last_push = -1;
  int d0, c0, p0;
  logic gap_chk = 1'b0;
  always @(posedge clk) cycle <= cycle + 1;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    push_t e;
    if (rst) begin
      if (audio_valid) begin
        pushes++;
        if (exp_push.size() == 0) chk("unexpected_push", 1, 0);
        else begin
          e = exp_push.pop_front();
          chk("push_data", audio_data, e.data);
          chk("push_count", sample_count, e.cnt);
          chk("push_done", done, e.done);
        end
        if (gap_chk && last_push >= 0) chk("push_gap", cycle - last_push, 4);
        last_push = cycle;
      end
      if (done) dones++;
      if (bus.wbm_cyc_o) cyc_cycles++;
      if (bus.wbm_cyc_o && bus.wbm_stb_o && (bus.wbm_ack_i || bus.wbm_err_i)) begin
        if (exp_adr.size() == 0) chk("unexpected_access", bus.wbm_adr_o, 32'hFFFFFFFF);
        else chk("wb_adr", bus.wbm_adr_o, exp_adr.pop_front());
      end
    end
  end
  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic exp_sample(logic [31:0] a, logic [15:0] c, logic d);
    exp_adr.push_back(a);
    exp_adr.push_back(a + 32'd4);
    exp_push.push_back({lo24(a), lo24(a + 32'd4), c, d});
  endtask
  task automatic wait_quiet(string name);
    int i;
    for (i = 0; i < 400; i++) begin
      tick(1);
      if (exp_push.size() == 0 && exp_adr.size() == 0 && !busy) break;
    end
    chk(name, i < 400, 1);
  endtask
  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    tick(3);
    chk("rst_adr", bus.wbm_adr_o, 0);
    chk("rst_cyc_stb", {bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
    chk("rst_valid", audio_valid, 0);
    chk("rst_busy_done_err", {busy, done, error}, 0);
    chk("rst_data", audio_data, 0);
    chk("rst_count", sample_count, 0);
    chk("const_we_sel", {bus.wbm_we_o, bus.wbm_sel_o}, 5'h0F);
    rst = 1'b1;
    tick(1);
    base_addr = 32'h100; length = 16'd3; loop = 1'b0;
    exp_sample(32'h100, 1, 0); exp_sample(32'h108, 2, 0); exp_sample(32'h110, 3, 1);
    gap_chk = 1'b1; last_push = -1; d0 = dones; enable = 1'b1;
    wait_quiet("t1_complete");
    gap_chk = 1'b0;
    chk("t1_dones", dones - d0, 1);
    chk("t1_count", sample_count, 3);
    tick(3);
    chk("t1_done_holds", {busy, bus.wbm_cyc_o, 32'(dones - d0)}, 34'd1);
    enable = 1'b0; tick(2);
    fifo_full = 1'b1; base_addr = 32'h200; length = 16'd1;
    exp_sample(32'h200, 1, 1); c0 = cyc_cycles; enable = 1'b1;
    tick(20);
    chk("t2_no_cyc_while_full", cyc_cycles - c0, 0);
    chk("t2_busy_waiting", busy, 1);
    fifo_full = 1'b0; tick(1);
    chk("t2_stb_after_full", bus.wbm_stb_o, 1);
    wait_quiet("t2_complete");
    enable = 1'b0; tick(2);
    base_addr = 32'h100; length = 16'd2; loop = 1'b1;
    repeat (3) begin
      exp_sample(32'h100, 1, 0); exp_sample(32'h108, 2, 1);
    end
    d0 = dones; p0 = pushes; enable = 1'b1;
    for (int i = 0; i < 200 && pushes - p0 < 6; i++) tick(1);
    chk("t3_six_pushes", pushes - p0, 6);
    enable = 1'b0; tick(3);
    chk("t3_dones", dones - d0, 3);
    chk("t3_idle", {busy, bus.wbm_cyc_o}, 0);
    chk("t3_drained", exp_adr.size() + exp_push.size(), 0);
    loop = 1'b0;
    base_addr = 32'h300; length = 16'd3; err_en = 1'b1; err_adr = 32'h30C;
    exp_sample(32'h300, 1, 0); exp_adr.push_back(32'h308); exp_adr.push_back(32'h30C);
    enable = 1'b1;
    for (int i = 0; i < 100 && !error; i++) tick(1);
    chk("t4_error", error, 1);
    chk("t4_cyc_dropped", bus.wbm_cyc_o, 0);
    chk("t4_not_busy", busy, 0);
    tick(2);
    chk("t4_error_sticky", error, 1);
    err_en = 1'b0; enable = 1'b0; tick(1);
    chk("t4_error_in_idle", error, 1);
    exp_sample(32'h300, 1, 0); exp_sample(32'h308, 2, 0); exp_sample(32'h310, 3, 1);
    enable = 1'b1; tick(1);
    chk("t4_error_cleared", error, 0);
    wait_quiet("t4_restart");
    enable = 1'b0; tick(2);
    lat = 5; base_addr = 32'h400; length = 16'd2;
    exp_adr.push_back(32'h400); p0 = pushes; enable = 1'b1;
    for (int i = 0; i < 20 && !bus.wbm_cyc_o; i++) tick(1);
    chk("t5_cyc_started", bus.wbm_cyc_o, 1);
    enable = 1'b0; tick(3);
    chk("t5_cyc_held", {bus.wbm_cyc_o, bus.wbm_stb_o}, 2'b11);
    for (int i = 0; i < 20 && bus.wbm_cyc_o; i++) tick(1);
    tick(1);
    chk("t5_idle", {busy, bus.wbm_cyc_o}, 0);
    chk("t5_no_push", pushes - p0, 0);
    chk("t5_access_done", exp_adr.size(), 0);
    lat = 3; exp_adr.push_back(32'h400); enable = 1'b1;
    for (int i = 0; i < 40 && !(bus.wbm_cyc_o && bus.wbm_adr_o == 32'h404); i++) tick(1);
    chk("t5_in_req_r", {bus.wbm_cyc_o, bus.wbm_adr_o}, {1'b1, 32'h404});
    rst = 1'b0; tick(1);
    chk("t5_rst_bus", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_adr_o}, 0);
    chk("t5_rst_status", {audio_valid, busy, done, error, sample_count}, 0);
    chk("t5_rst_data", audio_data, 0);
    rst = 1'b1; enable = 1'b0; lat = 0; tick(2);
    base_addr = 32'h500; length = 16'd0; d0 = dones; c0 = cyc_cycles; enable = 1'b1;
    tick(4);
    chk("t6_one_done", dones - d0, 1);
    chk("t6_no_cyc", cyc_cycles - c0, 0);
    chk("t6_idle_status", {busy, sample_count}, 0);
    enable = 1'b0; tick(2);
    both = 1'b1; err_en = 1'b1; err_adr = 32'h500; length = 16'd1;
    exp_adr.push_back(32'h500); p0 = pushes; enable = 1'b1;
    for (int i = 0; i < 40 && !error; i++) tick(1);
    chk("t6_err_wins", error, 1);
    tick(2);
    chk("t6_no_push", pushes - p0, 0);
    enable = 1'b0; both = 1'b0; err_en = 1'b0; tick(2);
    chk("all_drained", exp_adr.size() + exp_push.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
